// File: rtl/matmul_mem_engine.sv
// matmul_mem_engine: N x N unsigned matrix multiply C = A x B.
// Operands are fetched one word per cycle from a synchronous single-port RAM.
// Each C element is streamed through a valid/ready port and is also kept in c_flat.
module matmul_mem_engine #(
  parameter int DW     = 8,
  parameter int AW     = 6,
  parameter int N      = 2,
  parameter int A_BASE = 0,
  parameter int B_BASE = N*N,
  parameter int ACC_W  = 2*DW + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sat_i,
  output logic [AW-1:0]         addr_o,
  output logic                  rd_en_o,
  input  logic [DW-1:0]         data_i,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DW-1:0]         res_data,
  output logic [$clog2(N)-1:0]  res_row,
  output logic [$clog2(N)-1:0]  res_col,
  output logic [N*N*DW-1:0]     c_flat,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, LAST, OUT, DONE} state_t;

  state_t            state;
  logic [IW-1:0]     i, j, k;
  logic [DW-1:0]     a_reg;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic              mac_pending;
  logic              sat_q;

  // Word address of element (row, col) of a row-major N x N matrix at base; wraps modulo 2^AW.
  function automatic logic [AW-1:0] addr_calc(input int base, input logic [IW-1:0] row,
                                              input logic [IW-1:0] col);
    return AW'(base + int'(row) * N + int'(col));
  endfunction

  // Narrow the accumulator to DW bits: clamp to all-ones in saturate mode, else keep low bits.
  function automatic logic [DW-1:0] sat_wrap(input logic [ACC_W-1:0] v, input logic sat);
    if (sat && (v > ACC_W'({DW{1'b1}})))
      return {DW{1'b1}};
    return v[DW-1:0];
  endfunction

  // Accumulator value after the pending product (if any) is folded in this cycle.
  always_comb begin
    acc_next = acc;
    if (mac_pending)
      acc_next = acc + ACC_W'(a_reg) * ACC_W'(data_i);
  end

  // Control FSM with registered outputs; the MAC of the previous B word overlaps the next A read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      a_reg       <= '0;
      acc         <= '0;
      mac_pending <= 1'b0;
      sat_q       <= 1'b0;
      addr_o      <= '0;
      rd_en_o     <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_row     <= '0;
      res_col     <= '0;
      c_flat      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (mac_pending) begin
        acc         <= acc_next;
        mac_pending <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RD_A;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            acc     <= '0;
            c_flat  <= '0;
            sat_q   <= sat_i;
            busy    <= 1'b1;
            addr_o  <= addr_calc(A_BASE, '0, '0);
            rd_en_o <= 1'b1;
          end
        end
        RD_A: begin
          addr_o <= addr_calc(B_BASE, k, j);
          state  <= RD_B;
        end
        RD_B: begin
          a_reg       <= data_i;
          mac_pending <= 1'b1;
          if (k == LAST_IDX) begin
            rd_en_o <= 1'b0;
            state   <= LAST;
          end else begin
            k      <= k + IW'(1);
            addr_o <= addr_calc(A_BASE, i, k + IW'(1));
            state  <= RD_A;
          end
        end
        LAST: begin
          res_data  <= sat_wrap(acc_next, sat_q);
          res_row   <= i;
          res_col   <= j;
          res_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            c_flat[(int'(i) * N + int'(j)) * DW +: DW] <= res_data;
            acc <= '0;
            k   <= '0;
            if (j == LAST_IDX) begin
              j <= '0;
              if (i == LAST_IDX) begin
                i     <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                i       <= i + IW'(1);
                addr_o  <= addr_calc(A_BASE, i + IW'(1), '0);
                rd_en_o <= 1'b1;
                state   <= RD_A;
              end
            end else begin
              j       <= j + IW'(1);
              addr_o  <= addr_calc(A_BASE, i, '0);
              rd_en_o <= 1'b1;
              state   <= RD_A;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_mem_engine.sv
// Bench for matmul_mem_engine: an N=2 instance and an N=4 instance, each with its own RAM.
// A plain-arithmetic model builds the expected result stream; one compare process checks it.
module tb_matmul_mem_engine;
  localparam int DW = 8;
  localparam int AW = 6;

  typedef struct {
    int d;
    int r;
    int c;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // N=2 instance
  logic          start_a = 1'b0, sat_a = 1'b0, ready_a = 1'b1;
  logic [AW-1:0] addr_a;
  logic          rd_a, valid_a, busy_a, done_a;
  logic [DW-1:0] data_a, rdata_a;
  logic [0:0]    row_a, col_a;
  logic [31:0]   flat_a;
  logic [DW-1:0] mem_a [64];

  // N=4 instance
  logic          start_b = 1'b0, sat_b = 1'b0, ready_b = 1'b1;
  logic [AW-1:0] addr_b;
  logic          rd_b, valid_b, busy_b, done_b;
  logic [DW-1:0] data_b, rdata_b;
  logic [1:0]    row_b, col_b;
  logic [127:0]  flat_b;
  logic [DW-1:0] mem_b [64];

  matmul_mem_engine #(.DW(DW), .AW(AW), .N(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sat_i(sat_a), .addr_o(addr_a), .rd_en_o(rd_a),
    .data_i(data_a), .res_valid(valid_a), .res_ready(ready_a), .res_data(rdata_a),
    .res_row(row_a), .res_col(col_a), .c_flat(flat_a), .busy(busy_a), .done(done_a));

  matmul_mem_engine #(.DW(DW), .AW(AW), .N(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sat_i(sat_b), .addr_o(addr_b), .rd_en_o(rd_b),
    .data_i(data_b), .res_valid(valid_b), .res_ready(ready_b), .res_data(rdata_b),
    .res_row(row_b), .res_col(col_b), .c_flat(flat_b), .busy(busy_b), .done(done_b));

  // Synchronous RAMs: data appears the cycle after the address
  always @(posedge clk) begin
    if (rd_a) data_a <= mem_a[addr_a];
    if (rd_b) data_b <= mem_b[addr_b];
  end

  int errors = 0;
  int checks = 0;

  res_t qa[$];
  res_t qb[$];
  int   t0[2], first_v[2], last_hs[2], done_n[2], done_at[2];
  bit   held_v[2];
  int   held_d[2], held_r[2], held_c[2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic track(input int id, input logic v, input logic rdy, input int d, input int r,
                       input int c, input logic rd, input logic dn);
    res_t e;
    if (rst && v) begin
      if (first_v[id] < 0) first_v[id] = cyc - t0[id];
      chk("rd_en_during_out", rd, 1'b0);
      if (held_v[id]) begin
        chk("hold_data", d, held_d[id]);
        chk("hold_row", r, held_r[id]);
        chk("hold_col", c, held_c[id]);
      end
      if (rdy) begin
        if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
          chk("unexpected_result", 1, 0);
        end else begin
          if (id == 0) e = qa.pop_front();
          else         e = qb.pop_front();
          chk("res_data", d, e.d);
          chk("res_row", r, e.r);
          chk("res_col", c, e.c);
        end
        last_hs[id] = cyc - t0[id];
        held_v[id]  = 1'b0;
      end else begin
        held_v[id] = 1'b1;
        held_d[id] = d;
        held_r[id] = r;
        held_c[id] = c;
      end
    end else begin
      held_v[id] = 1'b0;
    end
    if (rst && dn) begin
      done_n[id]++;
      done_at[id] = cyc - t0[id];
    end
  endtask

  // Compare process: checks both instances' result ports on every falling edge
  always @(negedge clk) begin
    track(0, valid_a, ready_a, int'(rdata_a), int'(row_a), int'(col_a), rd_a, done_a);
    track(1, valid_b, ready_b, int'(rdata_b), int'(row_b), int'(col_b), rd_b, done_b);
  end

  // Model: C = A x B from RAM contents, narrowed by saturate or wrap
  task automatic model(input int id, input bit sat, output logic [127:0] flat);
    int   n, s, v;
    res_t e;
    n = (id == 0) ? 2 : 4;
    flat = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int kk = 0; kk < n; kk++) begin
          if (id == 0) s += int'(mem_a[i*n + kk]) * int'(mem_a[n*n + kk*n + j]);
          else         s += int'(mem_b[i*n + kk]) * int'(mem_b[n*n + kk*n + j]);
        end
        v = sat ? ((s > 255) ? 255 : s) : (s % 256);
        e.d = v; e.r = i; e.c = j;
        if (id == 0) qa.push_back(e);
        else         qb.push_back(e);
        flat[(i*n + j)*8 +: 8] = 8'(v);
      end
    end
  endtask

  task automatic run(input int id, input bit sat, input int hold, input bit extra_start);
    logic [127:0] exp_flat;
    int n, rel, budget;
    n = (id == 0) ? 2 : 4;
    model(id, sat, exp_flat);
    @(posedge clk); #1;
    first_v[id] = -1; last_hs[id] = -1; done_n[id] = 0; done_at[id] = -1; held_v[id] = 1'b0;
    t0[id] = cyc;
    if (id == 0) begin start_a = 1'b1; sat_a = sat; ready_a = (hold == 0); end
    else         begin start_b = 1'b1; sat_b = sat; end
    budget = 0;
    while (done_n[id] == 0 && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      rel = cyc - t0[id];
      if (id == 0) begin
        start_a = extra_start && (rel == 3);
        sat_a   = ~sat;
        if (hold > 0 && first_v[0] >= 0 && rel >= first_v[0] + hold) ready_a = 1'b1;
        if (rel == 1) chk("busy_running", busy_a, 1'b1);
      end else begin
        start_b = 1'b0;
        sat_b   = ~sat;
        if (rel == 1) chk("busy_running", busy_b, 1'b1);
      end
    end
    chk("done_seen", done_n[id] > 0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    chk("done_count", done_n[id], 1);
    chk("first_valid_cycle", first_v[id], 2*n + 2);
    chk("last_handshake_cycle", last_hs[id], n*n*(2*n + 2) + hold);
    chk("done_cycle", done_at[id], n*n*(2*n + 2) + hold + 1);
    if (id == 0) begin
      chk("stream_drained", qa.size(), 0);
      chk("busy_after", busy_a, 1'b0);
      chk("c_flat_model", flat_a, exp_flat);
    end else begin
      chk("stream_drained", qb.size(), 0);
      chk("busy_after", busy_b, 1'b0);
      chk("c_flat_model", flat_b, exp_flat);
    end
    qa.delete();
    qb.delete();
  endtask

  task automatic load_a(input int a0, a1, a2, a3, b0, b1, b2, b3);
    mem_a[0] = 8'(a0); mem_a[1] = 8'(a1); mem_a[2] = 8'(a2); mem_a[3] = 8'(a3);
    mem_a[4] = 8'(b0); mem_a[5] = 8'(b1); mem_a[6] = 8'(b2); mem_a[7] = 8'(b3);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_a"}, {addr_a, rd_a, valid_a, rdata_a, row_a, col_a, flat_a, busy_a, done_a}, '0);
    chk({tag, "_b"}, {addr_b, rd_b, valid_b, rdata_b, row_b, col_b, busy_b, done_b}, '0);
    chk({tag, "_b_flat"}, flat_b, '0);
  endtask

  localparam logic [31:0] C_BASIC = {8'd50, 8'd43, 8'd22, 8'd19};

  initial begin
    logic [127:0] lit_b;
    int rel;
    for (int a = 0; a < 64; a++) begin mem_a[a] = '0; mem_b[a] = '0; end
    for (int a = 0; a < 2; a++) begin t0[a] = 0; first_v[a] = -1; done_n[a] = 0; held_v[a] = 1'b0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset_state");
    rst = 1'b1;

    // Basic 2x2 product, wrap mode
    load_a(1, 2, 3, 4, 5, 6, 7, 8);
    run(0, 1'b0, 0, 1'b0);
    chk("c_flat_basic", flat_a, C_BASIC);

    // Large operands: saturate vs wrap
    load_a(200, 200, 200, 200, 200, 200, 200, 200);
    run(0, 1'b1, 0, 1'b0);
    chk("c_flat_sat", flat_a, {4{8'd255}});
    run(0, 1'b0, 0, 1'b0);
    chk("c_flat_wrap", flat_a, {4{8'd128}});

    // Back-pressure on the first result
    load_a(1, 2, 3, 4, 5, 6, 7, 8);
    run(0, 1'b0, 3, 1'b0);
    chk("c_flat_backpressure", flat_a, C_BASIC);

    // Second start pulse while busy
    run(0, 1'b0, 0, 1'b1);
    chk("c_flat_extra_start", flat_a, C_BASIC);

    // Reset asserted in cycle 4 of a run
    @(posedge clk); #1;
    t0[0] = cyc;
    start_a = 1'b1; sat_a = 1'b0;
    rel = 0;
    while (rel < 4) begin
      @(posedge clk); #1;
      rel = cyc - t0[0];
      start_a = 1'b0;
    end
    chk("rd_en_before_abort", rd_a, 1'b1);
    rst = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run(0, 1'b0, 0, 1'b0);
    chk("c_flat_after_reset", flat_a, C_BASIC);

    // 4x4: identity A, B[k][j] = 4k + j
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mem_b[r*4 + c]      = (r == c) ? 8'd1 : 8'd0;
        mem_b[16 + r*4 + c] = 8'(r*4 + c);
      end
    end
    run(1, 1'b0, 0, 1'b0);
    lit_b = '0;
    for (int e = 0; e < 16; e++) lit_b[e*8 +: 8] = 8'(e);
    chk("c_flat_n4_identity", flat_b, lit_b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time guard
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
